// File: rtl/ahb5_pkg.sv
// Shared AHB5 encodings, response constants and the subordinate memory FSM state type.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic AHB5_OKAY  = 1'b0;
  localparam logic AHB5_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Number of bytes moved by a transfer of the given HSIZE.
  function automatic int unsigned size_bytes(input logic [2:0] hsize);
    return 32'd1 << hsize;
  endfunction

endpackage

// File: rtl/ahb5_slave_mem_if.sv
// AHB5 bus signals between a manager and the subordinate memory.
interface ahb5_slave_mem_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  HSEL;
  logic [ADDR_W-1:0]     HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_W/8-1:0]   HWSTRB;
  logic [DATA_W-1:0]     HWDATA;
  logic                  HREADY;
  logic [DATA_W-1:0]     HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWSTRB, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWSTRB, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb5_mem_array.sv
// DEPTH x DATA_W storage with a byte-enable write port and asynchronous read; never reset.
module ahb5_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 subordinate memory: address decode, error checks, wait-state FSM and write commit.
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] ERR_BASE = 32'hFFFF_F000,
  parameter logic [31:0] ERR_SIZE = 32'h0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [3:0]  cfg_wait,
  ahb5_slave_mem_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = ADDR_W - LSB;
  localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH);
  localparam logic [63:0] WIN_LO = 64'(ERR_BASE);
  localparam logic [63:0] WIN_HI = 64'(ERR_BASE) + 64'(ERR_SIZE);
  localparam hsize_e MAX_SIZE = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;

  slv_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [STRB_W-1:0]   lanes_q, lanes_d;

  htrans_e             trans;
  logic [WIDX_W-1:0]   widx;
  logic [63:0]         addr_ext;
  logic [6:0]          align_mask;
  logic                err_range, err_win, err_align, err_size, acc_err;
  logic                accept, can_accept;
  int unsigned         lane_off, lane_cnt;
  logic [STRB_W-1:0]   lane_win;

  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;

  // Address-phase decode; all checks use the live bus so they match the accept edge.
  always_comb begin
    trans      = htrans_e'(bus.HTRANS);
    widx       = bus.HADDR[ADDR_W-1:LSB];
    addr_ext   = 64'(bus.HADDR);
    align_mask = (7'd1 << bus.HSIZE) - 7'd1;
    err_range  = widx >= DEPTH_IDX;
    err_win    = (ERR_SIZE != '0) && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    err_align  = |(bus.HADDR[6:0] & align_mask);
    err_size   = bus.HSIZE > MAX_SIZE;
    acc_err    = err_range | err_win | err_align | err_size;
    can_accept = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
    accept     = can_accept && bus.HSEL && bus.HREADY &&
                 ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
    lane_off   = 32'(bus.HADDR[LSB-1:0]);
    lane_cnt   = size_bytes(bus.HSIZE);
    lane_win   = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      lane_win[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            write_d = bus.HWRITE;
            idx_d   = bus.HADDR[LSB +: IDX_W];
            lanes_d = lane_win;
            if (cfg_wait == 4'd0) begin
              state_d = ST_LAST;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = cfg_wait - 4'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

  // Data-phase write lands on the edge that closes LAST; a reset on that edge cancels it.
  assign mem_we = (state_q == ST_LAST) && write_q && !HRESET;

  ahb5_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .addr  (idx_q),
    .wstrb (bus.HWSTRB & lanes_q),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign bus.HRDATA    = ((state_q == ST_WAIT) || (state_q == ST_LAST)) ? mem_rdata : '0;
  assign bus.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? AHB5_ERROR : AHB5_OKAY;
endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Directed bench for ahb5_slave_mem: timing, byte lanes, error responses and reset abort.
module tb_ahb5_slave_mem;
  import ahb5_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cfg_wait;
  int         n_tests = 0;
  int         n_fail  = 0;

  ahb5_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb5_slave_mem #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (1024),
    .ERR_BASE (32'h0000_0800),
    .ERR_SIZE (32'h0000_0010)
  ) dut (
    .HCLK     (clk),
    .HRESET   (rst),
    .cfg_wait (cfg_wait),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [1:0] tr);
    bus.HSEL   = 1'b1;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = sz;
    bus.HTRANS = tr;
  endtask

  task automatic idle_ph();
    bus.HSEL   = 1'b0;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;
    bus.HTRANS = HTRANS_IDLE;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                          input logic [2:0] sz, input logic [3:0] nw, input string tag);
    addr_ph(a, 1'b1, sz, HTRANS_NONSEQ);
    cfg_wait = nw;
    tick();
    idle_ph();
    bus.HWDATA = d;
    bus.HWSTRB = strb;
    for (int i = 0; i < int'(nw); i++) begin
      check({tag, "_wait_rdy"}, 32'(bus.HREADYOUT), 32'd0);
      tick();
    end
    check({tag, "_rdy"},  32'(bus.HREADYOUT), 32'd1);
    check({tag, "_resp"}, 32'(bus.HRESP),     32'd0);
    tick();
    bus.HWDATA = '0;
    bus.HWSTRB = '0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] nw, input logic [31:0] exp,
                         input logic [1:0] tr, input string tag);
    addr_ph(a, 1'b0, 3'd2, tr);
    cfg_wait = nw;
    tick();
    idle_ph();
    for (int i = 0; i < int'(nw); i++) begin
      check({tag, "_wait_rdy"}, 32'(bus.HREADYOUT), 32'd0);
      tick();
    end
    check({tag, "_rdy"},   32'(bus.HREADYOUT), 32'd1);
    check({tag, "_resp"},  32'(bus.HRESP),     32'd0);
    check({tag, "_rdata"}, bus.HRDATA,         exp);
    tick();
  endtask

  task automatic do_err(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input string tag);
    addr_ph(a, w, sz, HTRANS_NONSEQ);
    cfg_wait = 4'd0;
    tick();
    idle_ph();
    bus.HWDATA = '1;
    bus.HWSTRB = '1;
    check({tag, "_e1_rdy"},  32'(bus.HREADYOUT), 32'd0);
    check({tag, "_e1_resp"}, 32'(bus.HRESP),     32'd1);
    tick();
    check({tag, "_e2_rdy"},  32'(bus.HREADYOUT), 32'd1);
    check({tag, "_e2_resp"}, 32'(bus.HRESP),     32'd1);
    tick();
    check({tag, "_end_resp"}, 32'(bus.HRESP), 32'd0);
    bus.HWDATA = '0;
    bus.HWSTRB = '0;
  endtask

  initial begin
    idle_ph();
    bus.HWDATA = '0;
    bus.HWSTRB = '0;
    cfg_wait   = 4'd0;
    rst        = 1'b1;
    tick();
    tick();
    check("rst_rdy",   32'(bus.HREADYOUT), 32'd1);
    check("rst_resp",  32'(bus.HRESP),     32'd0);
    check("rst_rdata", bus.HRDATA,         32'd0);
    rst = 1'b0;
    tick();

    // Word write/read, zero wait
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 3'd2, 4'd0, "t1_wr");
    do_read (32'h10, 4'd0, 32'hDEAD_BEEF, HTRANS_NONSEQ, "t1_rd");

    // Three wait states on a read
    do_write(32'h20, 32'hCAFE_F00D, 4'hF, 3'd2, 4'd0, "t2_wr");
    do_read (32'h20, 4'd3, 32'hCAFE_F00D, HTRANS_NONSEQ, "t2_rd");

    // Byte and halfword lanes
    do_write(32'h10, 32'h1122_3344, 4'hF, 3'd2, 4'd0, "t3_wr");
    do_write(32'h13, 32'hA500_0000, 4'h8, 3'd0, 4'd0, "t3_b3");
    do_read (32'h10, 4'd0, 32'hA522_3344, HTRANS_NONSEQ, "t3_rd1");
    do_write(32'h11, 32'h7777_7777, 4'hF, 3'd0, 4'd0, "t3_b1");
    do_write(32'h12, 32'h5A5A_9999, 4'hF, 3'd1, 4'd1, "t3_h1");
    do_read (32'h10, 4'd0, 32'h5A5A_7744, HTRANS_NONSEQ, "t3_rd2");

    // Error responses; the unaligned write must not commit
    do_err(32'h1000, 1'b0, 3'd2, "t4_range");
    do_err(32'h0002, 1'b0, 3'd2, "t4_align");
    do_err(32'h0012, 1'b1, 3'd2, "t4_walign");
    do_err(32'h0018, 1'b1, 3'd3, "t4_size");
    do_err(32'h0808, 1'b0, 3'd2, "t4_win");
    do_read(32'h10, 4'd0, 32'h5A5A_7744, HTRANS_NONSEQ, "t4_unchg");
    do_write(32'h810, 32'h1234_5678, 4'hF, 3'd2, 4'd0, "t4_winend_wr");
    do_read (32'h810, 4'd0, 32'h1234_5678, HTRANS_NONSEQ, "t4_winend_rd");
    do_write(32'hFFC, 32'h0BAD_F00D, 4'hF, 3'd2, 4'd2, "t4_top_wr");
    do_read (32'hFFC, 4'd0, 32'h0BAD_F00D, HTRANS_SEQ, "t4_top_rd");

    // Back-to-back write then read, then IDLE and BUSY transfers
    addr_ph(32'h40, 1'b1, 3'd2, HTRANS_NONSEQ);
    cfg_wait = 4'd0;
    tick();
    bus.HWDATA = 32'h0000_0001;
    bus.HWSTRB = 4'hF;
    addr_ph(32'h40, 1'b0, 3'd2, HTRANS_NONSEQ);
    check("t5_wr_rdy", 32'(bus.HREADYOUT), 32'd1);
    tick();
    idle_ph();
    bus.HWDATA = '0;
    bus.HWSTRB = '0;
    check("t5_rd_rdy",   32'(bus.HREADYOUT), 32'd1);
    check("t5_rd_rdata", bus.HRDATA,         32'h0000_0001);
    tick();
    check("t5_idle_rdata", bus.HRDATA, 32'd0);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_IDLE;
    tick();
    check("t5_idle_rdy",  32'(bus.HREADYOUT), 32'd1);
    check("t5_idle_resp", 32'(bus.HRESP),     32'd0);
    bus.HTRANS = HTRANS_BUSY;
    tick();
    check("t5_busy_rdy", 32'(bus.HREADYOUT), 32'd1);
    idle_ph();

    // Reset during WAIT and during LAST of writes to 0x50
    do_write(32'h50, 32'h0, 4'hF, 3'd2, 4'd0, "t6_init");
    addr_ph(32'h50, 1'b1, 3'd2, HTRANS_NONSEQ);
    cfg_wait = 4'd3;
    tick();
    idle_ph();
    bus.HWDATA = 32'hFFFF_FFFF;
    bus.HWSTRB = 4'hF;
    check("t6_wait_rdy", 32'(bus.HREADYOUT), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_rdy",   32'(bus.HREADYOUT), 32'd1);
    check("t6_rst_resp",  32'(bus.HRESP),     32'd0);
    check("t6_rst_rdata", bus.HRDATA,         32'd0);
    addr_ph(32'h50, 1'b1, 3'd2, HTRANS_NONSEQ);
    cfg_wait = 4'd0;
    tick();
    idle_ph();
    check("t6_last_rdy", 32'(bus.HREADYOUT), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.HWDATA = '0;
    bus.HWSTRB = '0;
    do_read(32'h50, 4'd0, 32'h0, HTRANS_NONSEQ, "t6_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
